// File: rtl/ias_step_sequencer_pkg.sv
// Shared definitions for the IAS step sequencer: phase indices, opcodes, ALU encodings, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package ias_step_sequencer_pkg;

    // Bit positions of each phase in the stepper's one-hot vector
    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 3;
    localparam int P4 = 4;
    localparam int P5 = 5;
    localparam int P6 = 6;

    // IAS opcodes handled by this sequencer
    localparam logic [7:0] OP_HALT   = 8'h00;
    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_ADD    = 8'h05;
    localparam logic [7:0] OP_SUB    = 8'h06;
    localparam logic [7:0] OP_JMP_L  = 8'h0D;
    localparam logic [7:0] OP_JMP_R  = 8'h0E;
    localparam logic [7:0] OP_JMPP_L = 8'h0F;
    localparam logic [7:0] OP_JMPP_R = 8'h10;
    localparam logic [7:0] OP_STOR   = 8'h21;

    // ALU operation select, qualified by ac_ld
    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic {
        FETCH_L  = 1'b0,   // next instruction needs a fresh memory word
        DECODE_R = 1'b1    // right instruction already waiting in IBR
    } state_t;

    // Execute class of the latched opcode; exactly one of load..illegal is set.
    // 'right' marks a jump whose target is the right half of the word.
    typedef struct packed {
        logic load;
        logic add;
        logic sub;
        logic stor;
        logic jmp;
        logic jmpp;
        logic halt;
        logic right;
        logic illegal;
    } op_class_t;

    function automatic logic is_onehot7(input logic [6:0] v);
        return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
    endfunction

endpackage

// File: rtl/ias_op_decode.sv
// Combinational opcode classifier: maps the latched opcode to an execute-class one-hot plus illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op (opcode in), cls (execute class out).
module ias_op_decode
    import ias_step_sequencer_pkg::*;
#(
    parameter int OPC_W = 8
) (
    input  logic [OPC_W-1:0] op,
    output op_class_t        cls
);

    always_comb begin
        cls = '0;
        case (op)
            OPC_W'(OP_LOAD):   cls.load = 1'b1;
            OPC_W'(OP_ADD):    cls.add  = 1'b1;
            OPC_W'(OP_SUB):    cls.sub  = 1'b1;
            OPC_W'(OP_STOR):   cls.stor = 1'b1;
            OPC_W'(OP_JMP_L):  cls.jmp  = 1'b1;
            OPC_W'(OP_JMP_R): begin
                cls.jmp   = 1'b1;
                cls.right = 1'b1;
            end
            OPC_W'(OP_JMPP_L): cls.jmpp = 1'b1;
            OPC_W'(OP_JMPP_R): begin
                cls.jmpp  = 1'b1;
                cls.right = 1'b1;
            end
            OPC_W'(OP_HALT):   cls.halt = 1'b1;
            default:           cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ias_step_sequencer.sv
// Turns the stepper's one-hot phase into registered one-cycle datapath control pulses for IAS fetch/decode/execute.
// Latency: 1 cycle from the edge that first samples a new phase to the pulse.
// Backpressure: none; a phase held for many cycles produces a single pulse set.
// Ports: clk/rst (sync active-high); steps, opcode, ac_neg in; datapath pulses, ibr_sel/alu_op levels,
//        sticky halted/step_err and one-cycle illegal_op out.
module ias_step_sequencer
    import ias_step_sequencer_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int OPC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SIZE-1:0]  steps,
    input  logic [OPC_W-1:0] opcode,
    input  logic             ac_neg,
    output logic             mar_from_pc,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_ld,
    output logic             ibr_ld,
    output logic             ibr_sel,
    output logic             ac_ld,
    output logic [1:0]       alu_op,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             halted,
    output logic             step_err,
    output logic             illegal_op
);

    logic [6:0] stp;
    logic       unused_hi;
    assign stp       = steps[6:0];
    assign unused_hi = ^steps[SIZE-1:7];

    state_t           state;
    logic [6:0]       prev_step;
    logic [OPC_W-1:0] op_q;
    logic             skip_left;   // taken jump targeted a right half: next word decodes right only
    logic             cur_right;   // instruction in flight came from the right half
    logic             instr_vld;   // an instruction was loaded at P3 and not yet retired/discarded
    logic             jmp_taken;
    logic             jmp_right;

    op_class_t cls;
    logic      step_ok;
    logic      jmp_go;

    ias_op_decode #(.OPC_W(OPC_W)) u_dec (
        .op  (op_q),
        .cls (cls)
    );

    assign step_ok = is_onehot7(stp);
    assign jmp_go  = cls.jmp | (cls.jmpp & ~ac_neg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_L;
            prev_step   <= 7'b0000001;
            op_q        <= '0;
            skip_left   <= 1'b0;
            cur_right   <= 1'b0;
            instr_vld   <= 1'b0;
            jmp_taken   <= 1'b0;
            jmp_right   <= 1'b0;
            mar_from_pc <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            ir_ld       <= 1'b0;
            ibr_ld      <= 1'b0;
            ibr_sel     <= 1'b0;
            ac_ld       <= 1'b0;
            alu_op      <= ALU_PASS;
            pc_inc      <= 1'b0;
            pc_ld       <= 1'b0;
            halted      <= 1'b0;
            step_err    <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-armed below
            mar_from_pc <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            ir_ld       <= 1'b0;
            ibr_ld      <= 1'b0;
            ac_ld       <= 1'b0;
            pc_inc      <= 1'b0;
            pc_ld       <= 1'b0;
            illegal_op  <= 1'b0;

            if (!step_err) begin
                if (!step_ok) begin
                    // Corrupt stepper vector: freeze everything until reset
                    step_err <= 1'b1;
                end else if (stp != prev_step) begin
                    prev_step <= stp;
                    if (!halted) begin
                        if (stp[P0]) begin
                            // Stepper restarted mid-instruction: drop it, keep FSM state
                            instr_vld <= 1'b0;
                            jmp_taken <= 1'b0;
                        end else if (stp[P1]) begin
                            if (state == FETCH_L) mar_from_pc <= 1'b1;
                        end else if (stp[P2]) begin
                            if (state == FETCH_L) mem_rd <= 1'b1;
                        end else if (stp[P3]) begin
                            op_q      <= opcode;
                            ir_ld     <= 1'b1;
                            instr_vld <= 1'b1;
                            jmp_taken <= 1'b0;
                            if (state == DECODE_R || skip_left) begin
                                ibr_sel   <= 1'b1;
                                cur_right <= 1'b1;
                                skip_left <= 1'b0;
                            end else begin
                                ibr_sel   <= 1'b0;
                                ibr_ld    <= 1'b1;
                                cur_right <= 1'b0;
                            end
                        end else if (stp[P4]) begin
                            if (instr_vld && (cls.load || cls.add || cls.sub)) mem_rd <= 1'b1;
                        end else if (stp[P5]) begin
                            if (instr_vld) begin
                                if (cls.load) begin
                                    ac_ld  <= 1'b1;
                                    alu_op <= ALU_PASS;
                                end
                                if (cls.add) begin
                                    ac_ld  <= 1'b1;
                                    alu_op <= ALU_ADD;
                                end
                                if (cls.sub) begin
                                    ac_ld  <= 1'b1;
                                    alu_op <= ALU_SUB;
                                end
                                if (cls.stor)    mem_wr     <= 1'b1;
                                if (cls.halt)    halted     <= 1'b1;
                                if (cls.illegal) illegal_op <= 1'b1;
                                if (jmp_go) begin
                                    pc_ld     <= 1'b1;
                                    jmp_taken <= 1'b1;
                                    jmp_right <= cls.right;
                                end
                            end
                        end else if (stp[P6]) begin
                            if (instr_vld) begin
                                instr_vld <= 1'b0;
                                if (jmp_taken) begin
                                    // PC already holds the target word; fetch it fresh
                                    state     <= FETCH_L;
                                    skip_left <= jmp_right;
                                    jmp_taken <= 1'b0;
                                end else if (cur_right) begin
                                    pc_inc <= 1'b1;
                                    state  <= FETCH_L;
                                end else begin
                                    state <= DECODE_R;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ias_step_sequencer.sv
module tb_ias_step_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] steps;
    logic [7:0] opcode;
    logic       ac_neg;
    logic       mar_from_pc, mem_rd, mem_wr, ir_ld, ibr_ld, ibr_sel, ac_ld;
    logic [1:0] alu_op;
    logic       pc_inc, pc_ld, halted, step_err, illegal_op;

    ias_step_sequencer #(.SIZE(8), .OPC_W(8)) dut (
        .clk(clk), .rst(rst), .steps(steps), .opcode(opcode), .ac_neg(ac_neg),
        .mar_from_pc(mar_from_pc), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_ld(ir_ld),
        .ibr_ld(ibr_ld), .ibr_sel(ibr_sel), .ac_ld(ac_ld), .alu_op(alu_op),
        .pc_inc(pc_inc), .pc_ld(pc_ld), .halted(halted), .step_err(step_err),
        .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Observed pulse vector: ibr_sel only meaningful with ir_ld, alu_op only with ac_ld
    localparam logic [11:0] V_MAR = 12'h800, V_RD  = 12'h400, V_WR  = 12'h200, V_IR = 12'h100;
    localparam logic [11:0] V_IBR = 12'h080, V_AC  = 12'h040, V_INC = 12'h020, V_LD = 12'h010;
    localparam logic [11:0] V_ILL = 12'h008, V_SEL = 12'h004, A_ADD = 12'h001, A_SUB = 12'h002;

    logic [11:0] ov;
    assign ov = {mar_from_pc, mem_rd, mem_wr, ir_ld, ibr_ld, ac_ld, pc_inc, pc_ld, illegal_op,
                 ir_ld & ibr_sel, ac_ld ? alu_op : 2'b00};

    typedef struct {
        int          cyc;
        logic [11:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   hold  = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with any pulse must match the oldest expectation, on the predicted cycle
    always @(negedge clk) begin
        if (!rst && ov[11:3] != 9'd0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got %0h at cycle %0d expected none", ov, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_vec", {20'd0, ov}, {20'd0, e.vec});
                check("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    // Apply a raw steps value for 'hold' cycles; e is the pulse set expected one cycle later (0 = none)
    task automatic dr(input logic [7:0] s, input logic [11:0] e);
        exp_t x;
        steps = s;
        if (e != 12'd0) begin
            x.cyc = cyc + 1;
            x.vec = e;
            exp_q.push_back(x);
        end
        repeat (hold) @(negedge clk);
    endtask

    task automatic d(input int ph, input logic [11:0] e);
        dr(8'(1 << ph), e);
    endtask

    task automatic do_reset();
        steps = 8'h01;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        opcode = 8'h00;
        ac_neg = 1'b0;
        @(negedge clk);
        do_reset();
        check("reset_outputs", {20'd0, ov[11:3], ibr_sel, alu_op}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_step_err", {31'd0, step_err}, 32'd0);
        d(0, 0);

        // LOAD left then ADD right, every phase held 5 cycles
        hold = 5;
        opcode = 8'h01;
        d(1, V_MAR); d(2, V_RD); d(3, V_IR | V_IBR);
        opcode = 8'h21;                 // must be ignored: opcode latched at P3
        d(4, V_RD); d(5, V_AC); d(6, 0);
        opcode = 8'h05;
        d(1, 0); d(2, 0); d(3, V_IR | V_SEL);
        d(4, V_RD); d(5, V_AC | A_ADD); d(6, V_INC);
        hold = 2;

        // JUMP+ left with AC negative: not taken, then JUMP+ right half (AC positive) taken
        opcode = 8'h0F; ac_neg = 1'b1;
        d(1, V_MAR); d(2, V_RD); d(3, V_IR | V_IBR); d(4, 0); d(5, 0); d(6, 0);
        ac_neg = 1'b0;
        d(1, 0); d(2, 0); d(3, V_IR | V_SEL); d(4, 0); d(5, V_LD); d(6, 0);
        // JUMP+ left taken from the left half: no pc_inc, next word fetched
        d(1, V_MAR); d(2, V_RD); d(3, V_IR | V_IBR); d(4, 0); d(5, V_LD); d(6, 0);
        // JUMP+ to right half: next word decodes its right half directly
        opcode = 8'h10;
        d(1, V_MAR); d(2, V_RD); d(3, V_IR | V_IBR); d(4, 0); d(5, V_LD); d(6, 0);
        opcode = 8'h06;
        d(1, V_MAR); d(2, V_RD); d(3, V_IR | V_SEL); d(4, V_RD); d(5, V_AC | A_SUB); d(6, V_INC);

        // Illegal opcode (upper steps bit set must be ignored), then right-half restart via P0
        opcode = 8'h3F;
        d(1, V_MAR); dr(8'h84, V_RD); d(3, V_IR | V_IBR); d(4, 0); d(5, V_ILL); d(6, 0);
        opcode = 8'h01;
        d(1, 0); d(2, 0); d(3, V_IR | V_SEL); d(4, V_RD); d(0, 0); d(5, 0); d(6, 0);
        opcode = 8'h21;
        d(1, 0); d(2, 0); d(3, V_IR | V_SEL); d(4, 0); d(5, V_WR); d(6, V_INC);

        // HALT: sticky, suppresses everything afterwards
        opcode = 8'h00;
        d(1, V_MAR); d(2, V_RD); d(3, V_IR | V_IBR); d(4, 0); d(5, 0);
        check("halted_set", {31'd0, halted}, 32'd1);
        d(6, 0); d(1, 0); d(2, 0); d(3, 0);
        check("halted_sticky", {31'd0, halted}, 32'd1);

        // Multi-hot steps vector: sticky step_err, no further pulses until reset
        do_reset();
        check("halted_cleared", {31'd0, halted}, 32'd0);
        opcode = 8'h01;
        d(1, V_MAR);
        dr(8'h06, 0);
        check("step_err_set", {31'd0, step_err}, 32'd1);
        d(2, 0); d(3, 0); d(4, 0); d(5, 0); d(0, 0); d(1, 0);
        check("step_err_sticky", {31'd0, step_err}, 32'd1);
        do_reset();
        check("step_err_cleared", {31'd0, step_err}, 32'd0);
        d(1, V_MAR);

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
